// File: rtl/mux_pipe_reg.sv
`default_nettype none
// ============================================================================
//  Module   : mux_pipe_reg
//  Purpose  : N-way operand selector that feeds a pipeline stage register.
//             The register supports stall (hold), flush (bubble insertion)
//             and valid tracking. It also flags a captured valid operand
//             whose select was out of range, and counts consecutive stall
//             cycles with saturation.
//  Ports    : clk_i       - clock; all state updates on the rising edge
//             rst_i       - asynchronous, active-high reset
//             data_i      - NUM packed channels; channel k = data_i[k*SIZE +: SIZE]
//             select_i    - channel index
//             valid_i     - incoming operand is valid
//             stall_i     - hold register contents this cycle
//             flush_i     - load a bubble this cycle (beats stall_i)
//             data_o      - registered selected operand
//             valid_o     - data_o holds a valid operand
//             sel_err_o   - last captured valid operand had select_i >= NUM
//             stall_cnt_o - consecutive stall cycles, saturating at 255
//  Revision : 1.0 - initial release
// ============================================================================
module mux_pipe_reg #(
    parameter int              SIZE      = 32,
    parameter int              NUM       = 3,
    parameter int              SEL_W     = 2,
    parameter logic [SIZE-1:0] FLUSH_VAL = '0
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [NUM*SIZE-1:0] data_i,
    input  logic [SEL_W-1:0]    select_i,
    input  logic                valid_i,
    input  logic                stall_i,
    input  logic                flush_i,
    output logic [SIZE-1:0]     data_o,
    output logic                valid_o,
    output logic                sel_err_o,
    output logic [7:0]          stall_cnt_o
);

    // Illegal parameter combinations stop the build.
    generate
        if ((NUM < 2) || (NUM > 16) || ((2 ** SEL_W) < NUM)) begin : g_param_check
            $error("mux_pipe_reg: illegal parameters (need 2 <= NUM <= 16 and 2**SEL_W >= NUM)");
        end
    endgenerate

    // One extra bit so NUM itself is representable even when NUM == 2**SEL_W.
    localparam logic [SEL_W:0] c_num       = (SEL_W + 1)'(NUM);
    localparam int             c_slots     = 2 ** SEL_W;
    localparam logic [7:0]     c_stall_max = 8'hFF;

    // Every encodable select value maps to a slot. Slots beyond NUM alias
    // channel 0, so the read below never indexes past the array.
    logic [SIZE-1:0] w_chan [c_slots];

    generate
        for (genvar k = 0; k < c_slots; k++) begin : g_chan
            if (k < NUM) begin : g_real
                assign w_chan[k] = data_i[k*SIZE +: SIZE];
            end else begin : g_alias
                assign w_chan[k] = data_i[0 +: SIZE];
            end
        end
    endgenerate

    logic [SIZE-1:0] w_sel_data;
    logic            w_sel_oor;

    // When NUM == 2**SEL_W this comparison is constant-false and sel_err_o
    // can never be set.
    assign w_sel_data = w_chan[select_i];
    assign w_sel_oor  = ({1'b0, select_i} >= c_num);

    logic [SIZE-1:0] r_data;
    logic            r_valid;
    logic            r_sel_err;
    logic [7:0]      r_stall_cnt;

    // Priority per edge: flush, then stall, then load.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_data      <= FLUSH_VAL;
            r_valid     <= 1'b0;
            r_sel_err   <= 1'b0;
            r_stall_cnt <= 8'd0;
        end else if (flush_i) begin
            r_data      <= FLUSH_VAL;
            r_valid     <= 1'b0;
            r_sel_err   <= 1'b0;
            r_stall_cnt <= 8'd0;
        end else if (stall_i) begin
            if (r_stall_cnt != c_stall_max) begin
                r_stall_cnt <= r_stall_cnt + 8'd1;
            end
        end else begin
            // Data is captured even for an invalid operand; consumers
            // qualify it with valid_o.
            r_data      <= w_sel_data;
            r_valid     <= valid_i;
            r_sel_err   <= valid_i & w_sel_oor;
            r_stall_cnt <= 8'd0;
        end
    end

    assign data_o      = r_data;
    assign valid_o     = r_valid;
    assign sel_err_o   = r_sel_err;
    assign stall_cnt_o = r_stall_cnt;

endmodule
`default_nettype wire

// File: tb/tb_mux_pipe_reg.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mux_pipe_reg
//  Purpose  : Self-checking bench for mux_pipe_reg (SIZE=32, NUM=3, SEL_W=2,
//             FLUSH_VAL=0xDEADBEEF). A behavioural model tracks the expected
//             register state and each scenario task compares against it.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mux_pipe_reg;

    localparam int          SIZE      = 32;
    localparam int          NUM       = 3;
    localparam int          SEL_W     = 2;
    localparam logic [31:0] FLUSH_VAL = 32'hDEADBEEF;

    logic                clk;
    logic                rst;
    logic [SIZE-1:0]     ch [NUM];
    logic [NUM*SIZE-1:0] data_i;
    logic [SEL_W-1:0]    select_i;
    logic                valid_i;
    logic                stall_i;
    logic                flush_i;
    logic [SIZE-1:0]     data_o;
    logic                valid_o;
    logic                sel_err_o;
    logic [7:0]          stall_cnt_o;

    assign data_i = {ch[2], ch[1], ch[0]};

    mux_pipe_reg #(
        .SIZE      (SIZE),
        .NUM       (NUM),
        .SEL_W     (SEL_W),
        .FLUSH_VAL (FLUSH_VAL)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .data_i      (data_i),
        .select_i    (select_i),
        .valid_i     (valid_i),
        .stall_i     (stall_i),
        .flush_i     (flush_i),
        .data_o      (data_o),
        .valid_o     (valid_o),
        .sel_err_o   (sel_err_o),
        .stall_cnt_o (stall_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Expected register state.
    logic [31:0] m_data;
    logic        m_valid;
    logic        m_err;
    int          m_cnt;

    task automatic model_reset();
        m_data  = FLUSH_VAL;
        m_valid = 1'b0;
        m_err   = 1'b0;
        m_cnt   = 0;
    endtask

    // What one rising edge does, stated in terms of the selector's rules.
    task automatic model_edge();
        int s;
        s = int'(select_i);
        if (rst) begin
            model_reset();
        end else if (flush_i) begin
            model_reset();
        end else if (stall_i) begin
            m_cnt = (m_cnt >= 255) ? 255 : m_cnt + 1;
        end else begin
            m_data  = (s < NUM) ? ch[s] : ch[0];
            m_valid = valid_i;
            m_err   = valid_i && (s >= NUM);
            m_cnt   = 0;
        end
    endtask

    // Advance one edge: the model sees the inputs present at the edge,
    // outputs are sampled 1 time unit later.
    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic drive(input logic [1:0] sel, input logic v,
                         input logic st, input logic fl);
        select_i = sel;
        valid_i  = v;
        stall_i  = st;
        flush_i  = fl;
    endtask

    task automatic set_fixed_channels();
        ch[0] = 32'h11111111;
        ch[1] = 32'h22222222;
        ch[2] = 32'h33333333;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        set_fixed_channels();
        drive(2'd1, 1'b1, 1'b0, 1'b0);
        model_reset();
        tick();
        checks++;
        if ({data_o, valid_o, sel_err_o, stall_cnt_o} !== {FLUSH_VAL, 1'b0, 1'b0, 8'd0}) begin
            errors++;
            $display("FAIL reset: got data=%h v=%b e=%b cnt=%0d, want data=%h v=0 e=0 cnt=0",
                     data_o, valid_o, sel_err_o, stall_cnt_o, FLUSH_VAL);
        end
        rst = 1'b0;
    endtask

    task automatic test_load_seq();
        logic [31:0] want [3];
        want[0] = 32'h11111111;
        want[1] = 32'h22222222;
        want[2] = 32'h33333333;
        set_fixed_channels();
        for (int i = 0; i < 3; i++) begin
            drive(2'(i), 1'b1, 1'b0, 1'b0);
            tick();
            checks++;
            if ({data_o, valid_o, sel_err_o, stall_cnt_o} !== {want[i], 1'b1, 1'b0, 8'd0}) begin
                errors++;
                $display("FAIL load_seq sel=%0d: got data=%h v=%b e=%b cnt=%0d, want data=%h v=1 e=0 cnt=0",
                         i, data_o, valid_o, sel_err_o, stall_cnt_o, want[i]);
            end
        end
    endtask

    task automatic test_out_of_range();
        logic [1:0]  sel  [3];
        logic        vin  [3];
        logic [31:0] wdat [3];
        logic        wv   [3];
        logic        we   [3];
        sel[0] = 2'd3; vin[0] = 1'b1; wdat[0] = 32'h11111111; wv[0] = 1'b1; we[0] = 1'b1;
        sel[1] = 2'd1; vin[1] = 1'b1; wdat[1] = 32'h22222222; wv[1] = 1'b1; we[1] = 1'b0;
        sel[2] = 2'd3; vin[2] = 1'b0; wdat[2] = 32'h11111111; wv[2] = 1'b0; we[2] = 1'b0;
        set_fixed_channels();
        for (int i = 0; i < 3; i++) begin
            drive(sel[i], vin[i], 1'b0, 1'b0);
            tick();
            checks++;
            if ({data_o, valid_o, sel_err_o} !== {wdat[i], wv[i], we[i]}) begin
                errors++;
                $display("FAIL out_of_range step%0d: got data=%h v=%b e=%b, want data=%h v=%b e=%b",
                         i, data_o, valid_o, sel_err_o, wdat[i], wv[i], we[i]);
            end
        end
    endtask

    task automatic test_stall_hold();
        set_fixed_channels();
        drive(2'd1, 1'b1, 1'b0, 1'b0);
        tick();
        for (int i = 1; i <= 3; i++) begin
            drive(2'($urandom_range(0, 3)), 1'($urandom), 1'b1, 1'b0);
            tick();
            checks++;
            if ({data_o, valid_o, stall_cnt_o} !== {32'h22222222, 1'b1, 8'(i)}) begin
                errors++;
                $display("FAIL stall_hold cycle%0d: got data=%h v=%b cnt=%0d, want data=22222222 v=1 cnt=%0d",
                         i, data_o, valid_o, stall_cnt_o, i);
            end
        end
        drive(2'd2, 1'b1, 1'b0, 1'b0);
        tick();
        checks++;
        if ({data_o, valid_o, stall_cnt_o} !== {32'h33333333, 1'b1, 8'd0}) begin
            errors++;
            $display("FAIL stall_release: got data=%h v=%b cnt=%0d, want data=33333333 v=1 cnt=0",
                     data_o, valid_o, stall_cnt_o);
        end
    endtask

    task automatic test_saturation();
        drive(2'd0, 1'b1, 1'b1, 1'b0);
        for (int i = 1; i <= 300; i++) begin
            tick();
            checks++;
            if ({data_o, valid_o, sel_err_o, stall_cnt_o} !== {m_data, m_valid, m_err, 8'(m_cnt)}) begin
                errors++;
                $display("FAIL saturation cycle%0d: got data=%h v=%b e=%b cnt=%0d, want data=%h v=%b e=%b cnt=%0d",
                         i, data_o, valid_o, sel_err_o, stall_cnt_o, m_data, m_valid, m_err, m_cnt);
            end
        end
        checks++;
        if (stall_cnt_o !== 8'd255) begin
            errors++;
            $display("FAIL saturation_final: got cnt=%0d, want 255", stall_cnt_o);
        end
    endtask

    task automatic test_flush_vs_stall();
        set_fixed_channels();
        drive(2'd3, 1'b1, 1'b0, 1'b0);
        tick();
        drive(2'd2, 1'b1, 1'b1, 1'b0);
        tick();
        drive(2'd2, 1'b1, 1'b1, 1'b1);
        tick();
        checks++;
        if ({data_o, valid_o, sel_err_o, stall_cnt_o} !== {FLUSH_VAL, 1'b0, 1'b0, 8'd0}) begin
            errors++;
            $display("FAIL flush_vs_stall: got data=%h v=%b e=%b cnt=%0d, want data=%h v=0 e=0 cnt=0",
                     data_o, valid_o, sel_err_o, stall_cnt_o, FLUSH_VAL);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            for (int k = 0; k < NUM; k++) ch[k] = $urandom;
            drive(2'($urandom_range(0, 3)), 1'($urandom),
                  ($urandom_range(0, 9) < 3), ($urandom_range(0, 9) == 0));
            tick();
            checks++;
            if ({data_o, valid_o, sel_err_o, stall_cnt_o} !== {m_data, m_valid, m_err, 8'(m_cnt)}) begin
                errors++;
                $display("FAIL random cycle%0d: got data=%h v=%b e=%b cnt=%0d, want data=%h v=%b e=%b cnt=%0d",
                         i, data_o, valid_o, sel_err_o, stall_cnt_o, m_data, m_valid, m_err, m_cnt);
            end
        end
    endtask

    task automatic test_async_reset();
        set_fixed_channels();
        drive(2'd3, 1'b1, 1'b0, 1'b0);
        tick();
        drive(2'd1, 1'b1, 1'b1, 1'b0);
        tick();
        // Assert reset mid-cycle; outputs must clear before the next edge.
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        checks++;
        if ({data_o, valid_o, sel_err_o, stall_cnt_o} !== {FLUSH_VAL, 1'b0, 1'b0, 8'd0}) begin
            errors++;
            $display("FAIL async_reset: got data=%h v=%b e=%b cnt=%0d, want data=%h v=0 e=0 cnt=0",
                     data_o, valid_o, sel_err_o, stall_cnt_o, FLUSH_VAL);
        end
        drive(2'd2, 1'b1, 1'b0, 1'b0);
        tick();
        checks++;
        if ({data_o, valid_o, sel_err_o, stall_cnt_o} !== {FLUSH_VAL, 1'b0, 1'b0, 8'd0}) begin
            errors++;
            $display("FAIL async_reset_hold: got data=%h v=%b e=%b cnt=%0d, want data=%h v=0 e=0 cnt=0",
                     data_o, valid_o, sel_err_o, stall_cnt_o, FLUSH_VAL);
        end
        rst = 1'b0;
        tick();
        checks++;
        if ({data_o, valid_o, sel_err_o} !== {32'h33333333, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL first_after_reset: got data=%h v=%b e=%b, want data=33333333 v=1 e=0",
                     data_o, valid_o, sel_err_o);
        end
    endtask

    initial begin
        rst = 1'b1;
        drive(2'd0, 1'b0, 1'b0, 1'b0);
        set_fixed_channels();
        test_reset();
        test_load_seq();
        test_out_of_range();
        test_stall_hold();
        test_saturation();
        test_flush_vs_stall();
        test_random();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        errors++;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
